// File: rtl/dds_dac_spi.sv
// Serialises wave-ROM samples MSB-first to a TLC5615-style SPI DAC, with one pending-sample slot.
// Optional build macro DDS_DAC_SIGN_EN: treat samples as two's complement and convert to offset binary.
//
// state | meaning
// IDLE  | CS_N high, waiting for a pending or incoming sample
// SETUP | CS_N low, SCLK low, first bit on DIN for CLK_DIV cycles
// SHIFT | SCLK high/low phases, one bit per period, final low phase is CS hold
// GAP   | CS_N high for CS_GAP cycles before returning to IDLE
module dds_dac_spi #(
    parameter int DATA_W   = 10,
    parameter int PAD_BITS = 2,
    parameter int CLK_DIV  = 4,
    parameter int CS_GAP   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              dac_cs_n,
    output logic              dac_sclk,
    output logic              dac_din,
    output logic              busy,
    output logic              overrun
);

    localparam int N     = DATA_W + PAD_BITS;
    localparam int MAXC  = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int BIT_W = $clog2(N);

    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(CS_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LD = BIT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t            state_q;
    logic [N-1:0]      shift_q;
    logic [N-1:0]      frame_d;
    logic [CNT_W-1:0]  div_q;
    logic [BIT_W-1:0]  bit_q;
    logic [DATA_W-1:0] pend_q;
    logic              pend_full_q;
    logic              cs_n_q;
    logic              sclk_q;
    logic              din_q;
    logic              busy_q;
    logic              overrun_q;

    function automatic logic [N-1:0] to_frame(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] v;
        v = s;
`ifdef DDS_DAC_SIGN_EN
        v[DATA_W-1] = ~v[DATA_W-1];
`endif
        return N'(v) << PAD_BITS;
    endfunction

    // The pending slot has priority over a fresh sample when leaving IDLE.
    always_comb begin
        frame_d = to_frame(pend_full_q ? pend_q : sample_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            din_q       <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;

            if (state_q != IDLE && sample_valid) begin
                pend_q      <= sample_in;
                pend_full_q <= 1'b1;
                if (pend_full_q) begin
                    overrun_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (pend_full_q || sample_valid) begin
                        shift_q <= frame_d;
                        din_q   <= frame_d[N-1];
                        cs_n_q  <= 1'b0;
                        sclk_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        div_q   <= DIV_LD;
                        bit_q   <= BIT_LD;
                        state_q <= SETUP;
                        if (pend_full_q) begin
                            pend_full_q <= sample_valid;
                            pend_q      <= sample_in;
                        end
                    end
                end

                SETUP: begin
                    if (div_q == '0) begin
                        sclk_q  <= 1'b1;
                        div_q   <= DIV_LD;
                        state_q <= SHIFT;
                    end else begin
                        div_q <= div_q - CNT_W'(1);
                    end
                end

                SHIFT: begin
                    if (div_q != '0) begin
                        div_q <= div_q - CNT_W'(1);
                    end else if (sclk_q) begin
                        sclk_q <= 1'b0;
                        div_q  <= DIV_LD;
                        // Last bit: drive 0 through the CS hold phase.
                        if (bit_q == '0) begin
                            din_q <= 1'b0;
                        end else begin
                            shift_q <= shift_q << 1;
                            din_q   <= shift_q[N-2];
                        end
                    end else if (bit_q == '0) begin
                        cs_n_q  <= 1'b1;
                        div_q   <= GAP_LD;
                        state_q <= GAP;
                    end else begin
                        bit_q  <= bit_q - BIT_W'(1);
                        sclk_q <= 1'b1;
                        div_q  <= DIV_LD;
                    end
                end

                GAP: begin
                    if (div_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        div_q <= div_q - CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                    din_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dac_cs_n = cs_n_q;
    assign dac_sclk = sclk_q;
    assign dac_din  = din_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_dds_dac_spi.sv
// Scoreboard bench for dds_dac_spi: default instance plus a CLK_DIV=1 instance, frames decoded off the SPI pins.
module tb_dds_dac_spi;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] sample_w [2];
    logic       valid_w  [2];
    logic       cs_n_w   [2];
    logic       sclk_w   [2];
    logic       din_w    [2];
    logic       busy_w   [2];
    logic       ovr_w    [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [11:0] exp_q0 [$];
    logic [11:0] exp_q1 [$];

    logic [11:0] sh [2];
    int nb [2], len [2], fall_cyc [2], fall_prev [2], rise_cyc [2], gap_cyc [2];
    int idle_cyc [2], ovr_cnt [2], ovr_cyc [2];
    logic p_cs [2], p_sclk [2], p_busy [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dds_dac_spi u_dut0 (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_w[0]), .sample_valid(valid_w[0]),
        .dac_cs_n(cs_n_w[0]), .dac_sclk(sclk_w[0]), .dac_din(din_w[0]),
        .busy(busy_w[0]), .overrun(ovr_w[0])
    );

    dds_dac_spi #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_w[1]), .sample_valid(valid_w[1]),
        .dac_cs_n(cs_n_w[1]), .dac_sclk(sclk_w[1]), .dac_din(din_w[1]),
        .busy(busy_w[1]), .overrun(ovr_w[1])
    );

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] exp_frame(input logic [9:0] v);
        logic [9:0] c;
        c = v;
`ifdef DDS_DAC_SIGN_EN
        c[9] = ~c[9];
`endif
        return {c, 2'b00};
    endfunction

    task automatic frame_done(input int k, input logic [11:0] got);
        logic [11:0] e;
        if (k == 0) begin
            if (exp_q0.size() == 0) chk("frame0_unexpected", 1, 0);
            else begin e = exp_q0.pop_front(); chk("frame0_data", got, e); end
        end else begin
            if (exp_q1.size() == 0) chk("frame1_unexpected", 1, 0);
            else begin e = exp_q1.pop_front(); chk("frame1_data", got, e); end
        end
    endtask

    // Pin-level monitor: decodes bits on SCLK rising edges inside each CS_N low window.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                nb[k] = 0; len[k] = 0; sh[k] = '0;
                p_cs[k] = 1'b1; p_sclk[k] = 1'b0; p_busy[k] = 1'b0;
            end else begin
                if (ovr_w[k]) begin ovr_cnt[k]++; ovr_cyc[k] = cyc; end
                if (p_busy[k] && !busy_w[k]) idle_cyc[k] = cyc;
                if (!cs_n_w[k]) begin
                    if (p_cs[k]) begin
                        fall_prev[k] = fall_cyc[k];
                        fall_cyc[k]  = cyc;
                        gap_cyc[k]   = cyc - rise_cyc[k];
                        len[k] = 0; nb[k] = 0; sh[k] = '0;
                    end
                    len[k]++;
                    if (sclk_w[k] && !p_sclk[k]) begin
                        sh[k] = {sh[k][10:0], din_w[k]};
                        nb[k]++;
                    end
                end else if (!p_cs[k]) begin
                    rise_cyc[k] = cyc;
                    chk("frame_nbits", nb[k], 12);
                    chk("cs_low_len", len[k], (k == 0) ? 100 : 25);
                    frame_done(k, sh[k]);
                end
                p_cs[k] = cs_n_w[k]; p_sclk[k] = sclk_w[k]; p_busy[k] = busy_w[k];
            end
        end
    end

    task automatic at_cycle(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    task automatic send(input int k, input logic [9:0] v, input bit drops_prev);
        if (k == 0) begin
            if (drops_prev) void'(exp_q0.pop_back());
            exp_q0.push_back(exp_frame(v));
        end else begin
            if (drops_prev) void'(exp_q1.pop_back());
            exp_q1.push_back(exp_frame(v));
        end
        sample_w[k] = v;
        valid_w[k]  = 1'b1;
        @(posedge clk); #1;
        valid_w[k]  = 1'b0;
        sample_w[k] = 10'($urandom);
    endtask

    initial begin
        int t0, ob;
        for (int k = 0; k < 2; k++) begin
            sample_w[k] = '0; valid_w[k] = 1'b0;
            ovr_cnt[k] = 0; ovr_cyc[k] = -1; idle_cyc[k] = -1;
            fall_cyc[k] = -1; fall_prev[k] = -1; rise_cyc[k] = -1; gap_cyc[k] = -1;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs0", {cs_n_w[0], sclk_w[0], din_w[0], busy_w[0], ovr_w[0]}, 5'b10000);
        chk("rst_outs1", {cs_n_w[1], sclk_w[1], din_w[1], busy_w[1], ovr_w[1]}, 5'b10000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-frame, then a clean frame
        t0 = cyc;
        send(0, 10'h3C3, 1'b0);
        at_cycle(t0 + 40);
        exp_q0.delete();
        rst_n = 1'b0;
        #1;
        chk("midframe_rst", {cs_n_w[0], sclk_w[0], din_w[0], busy_w[0]}, 4'b1000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(0, 10'h0CC, 1'b0);
        repeat (110) @(posedge clk);
        #1;
        chk("after_rst_q_empty", exp_q0.size(), 0);

        // Single sample timing
        t0 = cyc;
        send(0, 10'h2A5, 1'b0);
        at_cycle(t0 + 110);
        chk("single_cs_fall", fall_cyc[0], t0 + 1);
        chk("single_cs_rise", rise_cyc[0], t0 + 101);
        chk("single_idle", idle_cyc[0], t0 + 103);
        chk("single_q_empty", exp_q0.size(), 0);

        // Back-to-back frames via the pending slot
        ob = ovr_cnt[0];
        t0 = cyc;
        send(0, 10'h1C3, 1'b0);
        at_cycle(t0 + 10);
        send(0, 10'h07E, 1'b0);
        at_cycle(t0 + 220);
        chk("b2b_fall_spacing", fall_cyc[0] - fall_prev[0], 103);
        chk("b2b_cs_gap", gap_cyc[0], 3);
        chk("b2b_no_overrun", ovr_cnt[0] - ob, 0);
        chk("b2b_q_empty", exp_q0.size(), 0);

        // Overrun: middle sample dropped
        ob = ovr_cnt[0];
        t0 = cyc;
        send(0, 10'h3A1, 1'b0);
        at_cycle(t0 + 10);
        send(0, 10'h111, 1'b0);
        at_cycle(t0 + 20);
        send(0, 10'h0F0, 1'b1);
        at_cycle(t0 + 220);
        chk("ovr_count", ovr_cnt[0] - ob, 1);
        chk("ovr_cycle", ovr_cyc[0], t0 + 21);
        chk("ovr_q_empty", exp_q0.size(), 0);

        // CLK_DIV=1 instance
        t0 = cyc;
        send(1, 10'h3FF, 1'b0);
        at_cycle(t0 + 40);
        chk("div1_cs_fall", fall_cyc[1], t0 + 1);
        chk("div1_idle", idle_cyc[1], t0 + 28);
        chk("div1_q_empty", exp_q1.size(), 0);

        // Zero sample: offset-binary conversion depends on the build
        send(0, 10'h000, 1'b0);
        send(1, 10'h000, 1'b0);
        repeat (110) @(posedge clk);
        #1;
        chk("zero_q0_empty", exp_q0.size(), 0);
        chk("zero_q1_empty", exp_q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
